mem_arbiter: RTL
================

# mem_arbiter

Byte-serial memory-port scheduler sharing the single 8-bit RAM/IO bus between the instruction fetcher (4-byte reads) and the load/store buffer (1/2/4-byte loads and stores). It sits between those two requesters and the external `mem_*` pins. It also sequences multi-byte transfers, stalls IO writes on a full UART buffer, and aborts speculative reads on ROB rollback.

## Interface
Parameters:
- `IO_HI`, 2'b11: value of `addr[17:16]` that marks IO space.

Ports (clock and reset first):
- Reset is asynchronous, active-high. There is one clock.
- `clk`, in, 1: system clock.
- `rst`, in, 1: asynchronous active-high reset.
- `rdy`, in, 1: global enable. When low, all state is frozen and `mem_wr` is forced to 0.
- `rollback`, in, 1: ROB misprediction flush.
- `mem_din`, in, 8: read data. Valid the cycle after its address.
- `mem_dout`, out, 8: write data.
- `mem_a`, out, 32: byte address.
- `mem_wr`, out, 1: 1 = write.
- `io_buffer_full`, in, 1: UART buffer full.
- `if_en`, in, 1: fetch request. Held until `if_done`.
- `if_pc`, in, 32: fetch address.
- `if_done`, out, 1: one-cycle completion pulse.
- `if_data`, out, 32: fetched word, little-endian.
- `lsb_en`, in, 1: LSB request. Held until `lsb_done`.
- `lsb_wr`, in, 1: 1 = store.
- `lsb_addr`, in, 32: byte address.
- `lsb_len`, in, 3: byte count, one of 1, 2 or 4.
- `lsb_w_data`, in, 32: store data. Low `lsb_len` bytes are used.
- `lsb_done`, out, 1: one-cycle completion pulse.
- `lsb_r_data`, out, 32: load data, zero-extended. Sign extension is the LSB's job.

## Operation
States are IDLE, RD, WR, DONE.
- **IDLE**
  - Samples `if_en` and `lsb_en`, then grants one requester.
  - Latches address, length (fixed at 4 for IF), write flag and write data.
  - Clears the byte counter and the assembly register.
  - Goes to RD or WR.
- **Arbitration**
  - A single requester is granted.
  - On a tie, the choice is set by the configuration macro (see Configuration).
  - `last_grant` records the owner of each grant. Its reset value is IF.
- **RD**
  - Drives `mem_a = base + cnt` and `mem_wr = 0`.
  - The byte sampled from `mem_din` one cycle later goes to assembly byte `cnt-1`.
  - After the last address, one extra cycle captures the final byte, then the FSM goes to DONE.
- **WR**
  - Drives `mem_a = base + cnt`, `mem_dout = data[8*cnt +: 8]` and `mem_wr = 1`. `cnt` increments.
  - After the last byte, goes to DONE.
  - IO stall: if `addr[17:16] == IO_HI` and `io_buffer_full` is high, the cycle drives `mem_wr = 0` and `mem_a = 0`, and `cnt` holds.
- **DONE**
  - Pulses the owner's `*_done` for one cycle and presents the data.
  - Ignores both `*_en` inputs, so a requester still holding `en` is not re-granted.
  - Returns to IDLE.
- **Rollback**
  - If high while the owner is in RD (IF or LSB), the FSM goes to IDLE at that edge and no done pulse is produced.
  - If high in DONE for a read, the done pulse is suppressed.
  - A WR in progress is a committed store: it completes normally and `lsb_done` fires.
  - In IDLE, a rollback cycle grants nothing.
- Idle bus values: `mem_a = 0`, `mem_dout = 0`, `mem_wr = 0`.
- Address arithmetic is 32-bit and wraps modulo 2^32.

## Timing
- **Reset values:**
  - State = IDLE.
  - All outputs = 0: `mem_a`, `mem_dout`, `mem_wr`, `if_done`, `if_data`, `lsb_done`, `lsb_r_data`.
  - `last_grant` = IF.
- Let C0 be the IDLE cycle in which a request is sampled.
- **Read of N bytes:**
  - Addresses are driven in C1..CN.
  - The last byte is captured at the end of C(N+1).
  - Done pulses in C(N+2).
  - IF latency is 6 cycles from C0.
- **Write of N bytes:**
  - Bytes are driven in C1..CN.
  - Done pulses in C(N+1).
  - Each IO stall cycle adds 1.
- The minimum gap between done pulses is 1 IDLE cycle.
- With `rdy` low, the FSM does not advance and `mem_wr = 0`. A read in flight must restart its current byte, so the counter does not advance on any cycle where `rdy` was low during capture.

## Configuration
- Macro: `MEM_ARB_RR_EN`.
- Defined: tie-break is round-robin. The requester not equal to `last_grant` wins, so alternate transfers go IF, LSB, IF...
- Undefined: LSB always wins ties. `last_grant` is still maintained but unused.

## Test plan
- IF read at `if_pc = 0x100` with memory bytes 13 00 00 00 → `if_done` pulses in C6 with `if_data = 0x00000013`, and `mem_wr` stays 0 throughout.
- LSB store of 2 bytes, `lsb_addr = 0x2000`, `lsb_w_data = 0xDEADBEEF` → C1 drives addr 0x2000 with 0xEF, C2 drives 0x2001 with 0xBE, and `lsb_done` pulses in C3.
- LSB 1-byte store to 0x30000 with `io_buffer_full` high for 3 cycles → `mem_wr` stays 0 for 3 cycles, then one write, and `lsb_done` arrives 3 cycles late.
- `if_en` and `lsb_en` held continuously → with `MEM_ARB_RR_EN`, grants go LSB, IF, LSB; without it, grants go LSB, LSB, LSB.
- `rollback` pulsed in C2 of an IF read → FSM returns to IDLE, no `if_done` is produced, and the next request is accepted.
- `rollback` pulsed mid LSB 4-byte store → all 4 bytes are written and `lsb_done` pulses.

Source files
------------

// File: rtl/mem_arbiter.sv
// Byte-serial scheduler sharing the 8-bit memory bus between instruction fetch and the LSB.
// Optional MEM_ARB_RR_EN selects round-robin tie-break; otherwise the LSB wins ties.
module mem_arbiter #(
  parameter logic [1:0] IO_HI = 2'b11
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        rollback,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic        io_buffer_full,
  input  logic        if_en,
  input  logic [31:0] if_pc,
  output logic        if_done,
  output logic [31:0] if_data,
  input  logic        lsb_en,
  input  logic        lsb_wr,
  input  logic [31:0] lsb_addr,
  input  logic [2:0]  lsb_len,
  input  logic [31:0] lsb_w_data,
  output logic        lsb_done,
  output logic [31:0] lsb_r_data
);

  typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_DONE} state_e;
  localparam logic OWN_IF  = 1'b0;
  localparam logic OWN_LSB = 1'b1;

  state_e      state_q;
  logic [2:0]  cnt_q, len_q;
  logic [31:0] base_q, wdata_q, asm_q;
  logic        wr_q, owner_q, last_grant_q, rdy_q;

  logic [31:0] cnt_ext_d;
  logic [4:0]  rd_bit_d, wr_bit_d;
  logic        io_stall_d, retry_d, grant_lsb_d;

  assign cnt_ext_d  = {29'b0, cnt_q};
  assign rd_bit_d   = {cnt_q[1:0] - 2'd1, 3'b000};
  assign wr_bit_d   = {cnt_q[1:0], 3'b000};
  assign io_stall_d = (state_q == S_WR) && (base_q[17:16] == IO_HI) && io_buffer_full;
  // A stalled cycle may have corrupted the byte in flight: re-issue its address, skip capture.
  assign retry_d    = (state_q == S_RD) && (cnt_q != 3'd0) && !rdy_q;

  always_comb begin
    grant_lsb_d = lsb_en;
`ifdef MEM_ARB_RR_EN
    if (if_en && lsb_en) grant_lsb_d = (last_grant_q == OWN_IF);
`endif
  end

`ifndef MEM_ARB_RR_EN
  logic unused_last_grant;
  assign unused_last_grant = last_grant_q;
`endif

  // Bus pins decode the registered state so IO stalls and rdy take effect in the same cycle.
  always_comb begin
    mem_a    = '0;
    mem_dout = '0;
    mem_wr   = 1'b0;
    case (state_q)
      S_RD: begin
        if (retry_d)             mem_a = base_q + cnt_ext_d - 32'd1;
        else if (cnt_q < len_q)  mem_a = base_q + cnt_ext_d;
      end
      S_WR: begin
        if (!io_stall_d) begin
          mem_a    = base_q + cnt_ext_d;
          mem_dout = wdata_q[wr_bit_d +: 8];
          mem_wr   = rdy;
        end
      end
      default: ;
    endcase
  end

  assign if_done    = rdy && (state_q == S_DONE) && (owner_q == OWN_IF) && !rollback;
  assign lsb_done   = rdy && (state_q == S_DONE) && (owner_q == OWN_LSB) && !(rollback && !wr_q);
  assign if_data    = ((state_q == S_DONE) && (owner_q == OWN_IF)) ? asm_q : '0;
  assign lsb_r_data = ((state_q == S_DONE) && (owner_q == OWN_LSB) && !wr_q) ? asm_q : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      len_q        <= '0;
      base_q       <= '0;
      wdata_q      <= '0;
      asm_q        <= '0;
      wr_q         <= 1'b0;
      owner_q      <= OWN_IF;
      last_grant_q <= OWN_IF;
      rdy_q        <= 1'b1;
    end else begin
      rdy_q <= rdy;
      if (rdy) begin
        case (state_q)
          S_IDLE: begin
            if (!rollback && (if_en || lsb_en)) begin
              owner_q      <= grant_lsb_d;
              last_grant_q <= grant_lsb_d;
              cnt_q        <= '0;
              asm_q        <= '0;
              if (grant_lsb_d) begin
                base_q  <= lsb_addr;
                len_q   <= lsb_len;
                wr_q    <= lsb_wr;
                wdata_q <= lsb_w_data;
                state_q <= lsb_wr ? S_WR : S_RD;
              end else begin
                base_q  <= if_pc;
                len_q   <= 3'd4;
                wr_q    <= 1'b0;
                wdata_q <= '0;
                state_q <= S_RD;
              end
            end
          end
          S_RD: begin
            if (rollback) begin
              state_q <= S_IDLE;
            end else if (!retry_d) begin
              if (cnt_q != 3'd0) asm_q[rd_bit_d +: 8] <= mem_din;
              if (cnt_q == len_q) state_q <= S_DONE;
              else                cnt_q   <= cnt_q + 3'd1;
            end
          end
          // Stores are committed: rollback does not interrupt them.
          S_WR: begin
            if (!io_stall_d) begin
              if (cnt_q == len_q - 3'd1) state_q <= S_DONE;
              else                       cnt_q   <= cnt_q + 3'd1;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

endmodule
